// File: rtl/hex_display_sequencer.sv
// Avalon-MM sequencer for six active-low seven-segment digits: value/ctrl/rate registers,
// tick prescaler, digit scrolling and (with `HEX_BLINK_EN defined) digit blinking.
module hex_display_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RATE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [23:0] v, input logic [2:0] idx);
    logic [3:0] n;
    case (idx)
      3'd0:    n = v[3:0];
      3'd1:    n = v[7:4];
      3'd2:    n = v[11:8];
      3'd3:    n = v[15:12];
      3'd4:    n = v[19:16];
      3'd5:    n = v[23:20];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] wrap6(input logic [3:0] s);
    logic [3:0] r;
    if (s >= 4'd6) begin
      r = s - 4'd6;
    end else begin
      r = s;
    end
    return r[2:0];
  endfunction

  logic        wr_s, wr_value_s, wr_ctrl_s, wr_rate_s, tick_s;
  logic [23:0] value_q, value_d;
  logic [5:0]  en_q, en_d;
  logic        scroll_q, scroll_d;
  logic [5:0]  dp_q, dp_d;
  logic [23:0] rate_q, rate_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  offset_q, offset_d;
  logic        seen_q, seen_d;
  logic [5:0][7:0] hex_q, hex_d;
  logic        blink_en_s, phase_s;
  logic [5:0]  bmask_s, blank_s;
  logic        unused_wdata_s;

  assign wr_s       = chipselect & ~write_n;
  assign wr_value_s = wr_s & (address == ADDR_VALUE);
  assign wr_ctrl_s  = wr_s & (address == ADDR_CTRL);
  assign wr_rate_s  = wr_s & (address == ADDR_RATE);
  assign unused_wdata_s = ^writedata[31:24];

  // Prescaler: a RATE write reloads the counter and swallows any tick that cycle
  always_comb begin
    tick_s = 1'b0;
    cnt_d  = cnt_q;
    if (wr_rate_s) begin
      cnt_d = writedata[23:0];
    end else if (cnt_q == 24'd0) begin
      if (rate_q != 24'd0) begin
        tick_s = 1'b1;
        cnt_d  = rate_q;
      end else begin
        cnt_d = 24'd0;
      end
    end else begin
      cnt_d = cnt_q - 24'd1;
    end
  end

  // Register file updates plus scroll offset and tick-seen flag
  always_comb begin
    value_d  = value_q;
    en_d     = en_q;
    scroll_d = scroll_q;
    dp_d     = dp_q;
    rate_d   = rate_q;
    offset_d = offset_q;
    seen_d   = seen_q;
    if (wr_value_s) begin
      value_d = writedata[23:0];
    end else begin
      value_d = value_q;
    end
    if (wr_ctrl_s) begin
      en_d     = writedata[5:0];
      scroll_d = writedata[6];
      dp_d     = writedata[21:16];
    end else begin
      en_d     = en_q;
      scroll_d = scroll_q;
      dp_d     = dp_q;
    end
    if (wr_rate_s) begin
      rate_d = writedata[23:0];
      seen_d = 1'b0;
    end else if (tick_s) begin
      seen_d = 1'b1;
    end else begin
      seen_d = seen_q;
    end
    // scroll_d already carries a same-edge CTRL write, so the new bit decides the step
    if (wr_ctrl_s && !writedata[6]) begin
      offset_d = 3'd0;
    end else if (tick_s && scroll_d) begin
      offset_d = (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
    end else begin
      offset_d = offset_q;
    end
  end

`ifdef HEX_BLINK_EN
  logic       blink_en_q, blink_en_d;
  logic [5:0] bmask_q, bmask_d;
  logic       phase_q, phase_d;

  // Blink control bits and phase toggle
  always_comb begin
    blink_en_d = blink_en_q;
    bmask_d    = bmask_q;
    phase_d    = phase_q;
    if (wr_ctrl_s) begin
      blink_en_d = writedata[7];
      bmask_d    = writedata[13:8];
    end else begin
      blink_en_d = blink_en_q;
      bmask_d    = bmask_q;
    end
    if (wr_ctrl_s && !writedata[7]) begin
      phase_d = 1'b0;
    end else if (tick_s && blink_en_d) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Blink state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_en_q <= 1'b0;
      bmask_q    <= 6'd0;
      phase_q    <= 1'b0;
    end else begin
      blink_en_q <= blink_en_d;
      bmask_q    <= bmask_d;
      phase_q    <= phase_d;
    end
  end

  assign blink_en_s = blink_en_q;
  assign bmask_s    = bmask_q;
  assign phase_s    = phase_q;
`else
  assign blink_en_s = 1'b0;
  assign bmask_s    = 6'd0;
  assign phase_s    = 1'b0;
`endif

  assign blank_s = phase_s ? bmask_s : 6'd0;

  // Per-digit segment pattern from the rotated nibble, enable, blink and dp masks
  always_comb begin
    hex_d = hex_q;
    for (int i = 0; i < 6; i++) begin
      if (!en_q[i] || blank_s[i]) begin
        hex_d[i] = 8'hFF;
      end else begin
        hex_d[i] = {~dp_q[i],
                    seg7(nibble_at(value_q, wrap6({1'b0, 3'(i)} + {1'b0, offset_q})))};
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_VALUE:  readdata = {8'd0, value_q};
      ADDR_CTRL:   readdata = {10'd0, dp_q, 2'd0, bmask_s, blink_en_s, scroll_q, en_q};
      ADDR_RATE:   readdata = {8'd0, rate_q};
      ADDR_STATUS: readdata = {27'd0, seen_q, phase_s, offset_q};
      default:     readdata = 32'd0;
    endcase
  end

  // Core state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q  <= 24'd0;
      en_q     <= 6'h3F;
      scroll_q <= 1'b0;
      dp_q     <= 6'd0;
      rate_q   <= 24'd0;
      cnt_q    <= 24'd0;
      offset_q <= 3'd0;
      seen_q   <= 1'b0;
      hex_q    <= {6{8'hFF}};
    end else begin
      value_q  <= value_d;
      en_q     <= en_d;
      scroll_q <= scroll_d;
      dp_q     <= dp_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      seen_q   <= seen_d;
      hex_q    <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule
